// File: rtl/imm_pkg.sv
// imm_pkg: format codes, opcode map and opcode-to-format decode shared by the immediate generator.
package imm_pkg;
    typedef logic [2:0] fmt_t;

    localparam fmt_t FMT_I   = 3'd0;
    localparam fmt_t FMT_S   = 3'd1;
    localparam fmt_t FMT_B   = 3'd2;
    localparam fmt_t FMT_J   = 3'd3;
    localparam fmt_t FMT_U   = 3'd4;
    localparam fmt_t FMT_Z   = 3'd5;
    localparam fmt_t FMT_BAD = 3'd7;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // CSR immediates (funct3[2]=1) carry zimm; register-form CSR ops fall back to I.
    function automatic fmt_t fmt_from_opcode(input logic [31:0] instr);
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_SYSTEM:                return instr[14] ? FMT_Z : FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_JAL:                   return FMT_J;
            OP_LUI, OP_AUIPC:         return FMT_U;
            default:                  return FMT_BAD;
        endcase
    endfunction
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out valid-ready bus of the immediate generator.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
    import imm_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    fmt_t            in_fmt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_t            out_fmt;
    logic            out_err;

    modport master (
        output in_valid, in_instr, in_fmt, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_err
    );
    modport slave (
        input  in_valid, in_instr, in_fmt, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_err
    );
endinterface

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extraction and XLEN extension for one format code.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_t            fmt,
    output logic [XLEN-1:0] imm,
    output logic            err
);
    logic        s;
    logic [31:0] raw;

    assign s   = instr[31];
    assign err = fmt[2] & fmt[1];

    // zimm keeps bit 31 clear, so the common sign extension below leaves it zero-extended.
    always_comb begin
        case (fmt)
            FMT_I:   raw = {{20{s}}, instr[31:20]};
            FMT_S:   raw = {{20{s}}, instr[31:25], instr[11:7]};
            FMT_B:   raw = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   raw = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   raw = {instr[31:12], 12'b0};
            FMT_Z:   raw = {27'b0, instr[19:15]};
            default: raw = '0;
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign imm = {{(XLEN-32){raw[31]}}, raw};
    end else begin : g_narrow
        assign imm = raw;
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a registered 2-entry valid/ready output buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  bus
);
    fmt_t                       sel_fmt;
    logic [XLEN-1:0]            ext_imm;
    logic                       ext_err;
    logic [1:0][XLEN-1:0]       imm_q;
    logic [1:0][2:0]            fmt_q;
    logic [1:0]                 err_q;
    logic [1:0]                 count;
    logic [1:0]                 count_n;
    logic                       wr;
    logic                       rd;
    logic                       ready_q;
    logic                       push;
    logic                       pop;

    assign sel_fmt = AUTO_DECODE ? fmt_from_opcode(bus.in_instr) : bus.in_fmt;

    imm_extend_core #(.XLEN(XLEN)) u_core (
        .instr (bus.in_instr[31:7]),
        .fmt   (sel_fmt),
        .imm   (ext_imm),
        .err   (ext_err)
    );

    assign push    = bus.in_valid & ready_q;
    assign pop     = (count != 2'd0) & bus.out_ready;
    assign count_n = count + {1'b0, push} - {1'b0, pop};

    // in_ready is registered from the next count so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wr      <= 1'b0;
            rd      <= 1'b0;
            ready_q <= 1'b1;
            imm_q   <= '0;
            fmt_q   <= '0;
            err_q   <= '0;
        end else begin
            count   <= count_n;
            ready_q <= count_n != 2'd2;
            if (push) begin
                wr        <= ~wr;
                imm_q[wr] <= ext_imm;
                fmt_q[wr] <= sel_fmt;
                err_q[wr] <= ext_err;
            end
            if (pop) rd <= ~rd;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = count != 2'd0;
    assign bus.out_imm   = imm_q[rd];
    assign bus.out_fmt   = fmt_q[rd];
    assign bus.out_err   = err_q[rd];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives XLEN=32, XLEN=64 and explicit-format instances in lockstep against a queue model.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_fmt = '0;
    logic        out_ready = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  f;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();
    imm_gen_pipe_if #(.XLEN(32)) bm ();

    assign b32.in_valid = in_valid;  assign b32.in_instr = in_instr;
    assign b32.in_fmt = in_fmt;      assign b32.out_ready = out_ready;
    assign b64.in_valid = in_valid;  assign b64.in_instr = in_instr;
    assign b64.in_fmt = in_fmt;      assign b64.out_ready = out_ready;
    assign bm.in_valid = in_valid;   assign bm.in_instr = in_instr;
    assign bm.in_fmt = in_fmt;       assign bm.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dutm  (.clk(clk), .rst_n(rst_n), .bus(bm));

    // Reference: immediate value as a signed integer built from the instruction fields.
    function automatic void ref_model(input logic [31:0] ins, input logic [2:0] fi, input bit auto,
                                      output logic [2:0] fo, output logic err, output logic [63:0] imm);
        int     x = ins;
        int     op = x & 127;
        longint v;
        fo = fi;
        if (auto) begin
            if (op == 19 || op == 3 || op == 103) fo = 0;
            else if (op == 115) fo = ins[14] ? 3'd5 : 3'd0;
            else if (op == 35) fo = 1;
            else if (op == 99) fo = 2;
            else if (op == 111) fo = 3;
            else if (op == 55 || op == 23) fo = 4;
            else fo = 7;
        end
        case (fo)
            3'd0: v = x >>> 20;
            3'd1: v = (x >>> 25) * 32 + ((x >> 7) & 31);
            3'd2: v = (x >>> 31) * 4096 + ((x >> 7) & 1) * 2048 + ((x >> 25) & 63) * 32 + ((x >> 8) & 15) * 2;
            3'd3: v = (x >>> 31) * 1048576 + ((x >> 12) & 255) * 4096 + ((x >> 20) & 1) * 2048
                      + ((x >> 21) & 1023) * 2;
            3'd4: v = x & -4096;
            3'd5: v = (x >> 15) & 31;
            default: v = 0;
        endcase
        err = fo >= 6;
        imm = v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'd19, 7'd3, 7'd103, 7'd115, 7'd35, 7'd99, 7'd111, 7'd55, 7'd23, 7'd127};
        int          k = $urandom_range(0, 10);
        logic [31:0] r = $urandom;
        logic [6:0]  op = r[6:0];
        if (k < 10) op = ops[k];
        return {r[31:7], op};
    endfunction

    // One clock: compare every instance against the model head, then advance the model.
    task automatic step(input string tag);
        logic [69:0] got, ex;
        logic [2:0]  f;
        logic        e;
        logic [63:0] v;
        bit          pu, po;
        for (int k = 0; k < 3; k++) begin
            got = k == 0 ? {b32.out_valid, b32.in_ready, b32.out_err, b32.out_fmt, 32'b0, b32.out_imm}
                : k == 1 ? {b64.out_valid, b64.in_ready, b64.out_err, b64.out_fmt, b64.out_imm}
                :          {bm.out_valid, bm.in_ready, bm.out_err, bm.out_fmt, 32'b0, bm.out_imm};
            ex = {q.size() != 0, q.size() != 2, 68'b0};
            if (q.size() == 0) got[67:0] = '0;
            else begin
                ref_model(q[0].ins, q[0].f, k != 2, f, e, v);
                ex[67:0] = {e, f, k == 1 ? v : {32'b0, v[31:0]}};
            end
            checks++;
            if (got !== ex) begin
                errors++;
                $display("FAIL %s dut%0d got %h exp %h", tag, k, got, ex);
            end
        end
        pu = in_valid && q.size() != 2;
        po = q.size() != 0 && out_ready;
        @(posedge clk);
        if (po) void'(q.pop_front());
        if (pu) q.push_back('{in_instr, in_fmt});
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({b32.out_valid, b32.in_ready, b32.out_imm, b32.out_fmt, b32.out_err} !== {1'b0, 1'b1, 36'b0}) begin
            errors++;
            $display("FAIL reset32 got %b", {b32.out_valid, b32.in_ready, b32.out_imm, b32.out_fmt, b32.out_err});
        end
        checks++;
        if ({b64.out_valid, b64.in_ready, b64.out_imm, b64.out_fmt, b64.out_err} !== {1'b0, 1'b1, 68'b0}) begin
            errors++;
            $display("FAIL reset64 got %h", {b64.out_valid, b64.in_ready, b64.out_imm, b64.out_fmt, b64.out_err});
        end
        step("reset_idle");
    endtask

    task automatic test_addi();
        out_ready = 1; in_valid = 1; in_instr = 32'hFFF00093; in_fmt = 0;
        step("addi_push");
        in_valid = 0;
        checks++;
        if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_err} !== {1'b1, 32'hFFFFFFFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL addi got v=%b imm=%h fmt=%0d err=%b exp 1 ffffffff 0 0",
                     b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_err);
        end
        step("addi_out");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3] = '{32'hFE112E23, 32'hFE000CE3, 32'h0010006F};
        logic [31:0] exp [3] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = ins[i];
            step("b2b_push");
            checks++;
            if (b32.out_valid !== 1'b1 || b32.out_imm !== exp[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got v=%b imm=%h exp 1 %h", i, b32.out_valid, b32.out_imm, exp[i]);
            end
        end
        in_valid = 0;
        step("b2b_drain");
    endtask

    task automatic test_xlen64();
        logic [31:0] ins [3] = '{32'h800000B7, 32'h123450B7, 32'h3401F073};
        logic [63:0] exp [3] = '{64'hFFFFFFFF80000000, 64'h0000000012345000, 64'h3};
        logic [2:0]  ef [3] = '{3'd4, 3'd4, 3'd5};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = ins[i];
            step("x64_push");
            checks++;
            if (b64.out_imm !== exp[i] || b64.out_fmt !== ef[i]) begin
                errors++;
                $display("FAIL x64[%0d] got imm=%h fmt=%0d exp %h %0d", i, b64.out_imm, b64.out_fmt, exp[i], ef[i]);
            end
        end
        in_valid = 0;
        step("x64_drain");
    endtask

    task automatic test_stall();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = rand_instr(); in_fmt = 3'($urandom_range(0, 5));
            step("stall_push");
            if (i == 1) begin
                checks++;
                if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_full got in_ready=%b out_valid=%b exp 0 1", b32.in_ready, b32.out_valid);
                end
            end
        end
        out_ready = 1;
        step("stall_release");
        in_valid = 0;
        for (int i = 0; i < 4; i++) step("stall_drain");
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1; in_instr = 32'h0000007F; in_fmt = 3'd6;
        step("bad_push");
        in_valid = 0;
        checks++;
        if ({b32.out_err, b32.out_imm, b32.out_fmt} !== {1'b1, 32'b0, 3'd7}) begin
            errors++;
            $display("FAIL bad_auto got err=%b imm=%h fmt=%0d exp 1 0 7", b32.out_err, b32.out_imm, b32.out_fmt);
        end
        checks++;
        if ({bm.out_err, bm.out_imm, bm.out_fmt} !== {1'b1, 32'b0, 3'd6}) begin
            errors++;
            $display("FAIL bad_fmt got err=%b imm=%h fmt=%0d exp 1 0 6", bm.out_err, bm.out_imm, bm.out_fmt);
        end
        step("bad_out");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_instr = rand_instr();
            in_fmt = 3'($urandom_range(0, 7));
            step("random");
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) step("random_drain");
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_instr = rand_instr(); in_fmt = 3'($urandom_range(0, 5));
            step("ar_fill");
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({b32.out_valid, b32.in_ready, b32.out_imm, b64.out_valid, b64.in_ready, b64.out_imm}
            !== {1'b0, 1'b1, 32'b0, 1'b0, 1'b1, 64'b0}) begin
            errors++;
            $display("FAIL async_reset got v=%b r=%b imm=%h v64=%b r64=%b imm64=%h exp 0 1 0",
                     b32.out_valid, b32.in_ready, b32.out_imm, b64.out_valid, b64.in_ready, b64.out_imm);
        end
        q.delete();
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        step("ar_idle");
        out_ready = 1; in_valid = 1; in_instr = 32'hFFF00093; in_fmt = 0;
        step("ar_push");
        in_valid = 0;
        step("ar_single");
        step("ar_empty");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_addi();
        test_back_to_back();
        test_xlen64();
        test_stall();
        test_illegal();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
